// File: rtl/bpu_gshare.sv
// Fetch-stage branch predictor: static / bimodal / gshare direction, J/B immediate targets, tagged BTB for JALR.
// Lookup is combinational (0 cycles); PHT, BTB and GHR updates land on the next rising edge with no bypass.
module bpu_gshare #(
  parameter int         MODE      = 2,
  parameter int         PHT_IDX_W = 6,
  parameter int         GHR_W     = 6,
  parameter int         BTB_IDX_W = 4,
  parameter int         TAG_W     = 8,
  parameter logic [1:0] CTR_INIT  = 2'b10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst_i,
  input  logic [31:0]      inst_addr_i,
  input  logic             pred_fire_i,
  output logic             bp_result_o,
  output logic [31:0]      bp_jump_addr_o,
  output logic [GHR_W-1:0] bp_ghr_o,
  input  logic             upd_valid_i,
  input  logic [31:0]      upd_addr_i,
  input  logic             upd_is_cond_i,
  input  logic             upd_is_jalr_i,
  input  logic             upd_taken_i,
  input  logic [31:0]      upd_target_i,
  input  logic             upd_mispredict_i,
  input  logic [GHR_W-1:0] upd_ghr_i
);
  localparam int         PHT_N   = 1 << PHT_IDX_W;
  localparam int         BTB_N   = 1 << BTB_IDX_W;
  localparam bit         STATIC  = (MODE == 0);
  localparam bit         GSHARE  = (MODE >= 2);
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  logic [1:0]       r_pht     [PHT_N];
  logic [BTB_N-1:0] r_btb_vld;
  logic [TAG_W-1:0] r_btb_tag [BTB_N];
  logic [31:0]      r_btb_tgt [BTB_N];
  logic [GHR_W-1:0] r_ghr;

  logic                 w_is_jal, w_is_br, w_is_jalr;
  logic [31:0]          w_j_imm, w_b_imm;
  logic [PHT_IDX_W-1:0] w_pht_idx, w_upd_pidx;
  logic [1:0]           w_ctr, w_upd_ctr;
  logic                 w_br_taken;
  logic [BTB_IDX_W-1:0] w_btb_idx, w_upd_bidx;
  logic [TAG_W-1:0]     w_btb_tag, w_upd_btag;
  logic                 w_btb_hit;
  logic                 w_upd_cond, w_upd_jalr;
  logic [GHR_W-1:0]     w_ghr_rec, w_ghr_spec;
  logic                 w_unused;

  assign w_is_jal  = (inst_i[6:0] == OP_JAL);
  assign w_is_br   = (inst_i[6:0] == OP_BR);
  assign w_is_jalr = (inst_i[6:0] == OP_JALR);
  assign w_j_imm   = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign w_b_imm   = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};

  // History is zero-extended into the low index bits before the XOR.
  assign w_pht_idx  = inst_addr_i[PHT_IDX_W+1:2] ^ (GSHARE ? PHT_IDX_W'(r_ghr) : '0);
  assign w_ctr      = r_pht[w_pht_idx];
  assign w_br_taken = STATIC ? inst_i[31] : w_ctr[1];

  assign w_btb_idx = inst_addr_i[BTB_IDX_W+1:2];
  assign w_btb_tag = inst_addr_i[BTB_IDX_W+TAG_W+1:BTB_IDX_W+2];
  assign w_btb_hit = r_btb_vld[w_btb_idx] && (r_btb_tag[w_btb_idx] == w_btb_tag);

  always_comb begin
    bp_result_o    = 1'b0;
    bp_jump_addr_o = 32'h0;
    if (!rst) begin
      if (w_is_jal) begin
        bp_result_o    = 1'b1;
        bp_jump_addr_o = inst_addr_i + w_j_imm;
      end else if (w_is_br) begin
        bp_result_o    = w_br_taken;
        bp_jump_addr_o = w_br_taken ? inst_addr_i + w_b_imm : 32'h0;
      end else if (w_is_jalr && w_btb_hit) begin
        bp_result_o    = 1'b1;
        bp_jump_addr_o = r_btb_tgt[w_btb_idx];
      end
    end
  end

  assign bp_ghr_o = rst ? '0 : r_ghr;

  assign w_upd_cond = upd_valid_i & upd_is_cond_i;
  assign w_upd_jalr = upd_valid_i & upd_is_jalr_i;
  assign w_upd_pidx = upd_addr_i[PHT_IDX_W+1:2] ^ (GSHARE ? PHT_IDX_W'(upd_ghr_i) : '0);
  assign w_upd_ctr  = r_pht[w_upd_pidx];
  assign w_upd_bidx = upd_addr_i[BTB_IDX_W+1:2];
  assign w_upd_btag = upd_addr_i[BTB_IDX_W+TAG_W+1:BTB_IDX_W+2];
  // Truncating casts keep the shift legal when GHR_W is 1.
  assign w_ghr_rec  = GHR_W'({upd_ghr_i, upd_taken_i});
  assign w_ghr_spec = GHR_W'({r_ghr, bp_result_o});

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHT_N; i++) r_pht[i] <= CTR_INIT;
      r_btb_vld <= '0;
      r_ghr     <= '0;
    end else begin
      if (w_upd_cond) begin
        if (upd_taken_i && w_upd_ctr != 2'b11)
          r_pht[w_upd_pidx] <= w_upd_ctr + 2'd1;
        else if (!upd_taken_i && w_upd_ctr != 2'b00)
          r_pht[w_upd_pidx] <= w_upd_ctr - 2'd1;
      end
      if (w_upd_jalr) begin
        r_btb_vld[w_upd_bidx] <= 1'b1;
        r_btb_tag[w_upd_bidx] <= w_upd_btag;
        r_btb_tgt[w_upd_bidx] <= upd_target_i;
      end
      // Mispredict recovery wins over the speculative shift of a flushed fetch.
      if (w_upd_cond && upd_mispredict_i)
        r_ghr <= w_ghr_rec;
      else if (pred_fire_i && w_is_br)
        r_ghr <= w_ghr_spec;
    end
  end

  assign w_unused = ^{upd_addr_i, w_ctr[0]};
endmodule

// File: tb/tb_bpu_gshare.sv
// Bench for bpu_gshare: three instances (static, bimodal, gshare) share stimulus; expectations are queued per cycle and checked mid-cycle.
module tb_bpu_gshare;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, pred_fire_i;
  logic [31:0] inst_i, inst_addr_i;
  logic        upd_valid_i, upd_is_cond_i, upd_is_jalr_i, upd_taken_i, upd_mispredict_i;
  logic [31:0] upd_addr_i, upd_target_i;
  logic [5:0]  upd_ghr_i;
  logic [2:0]        res;
  logic [2:0][31:0]  tgt;
  logic [2:0][5:0]   ghr;

  localparam logic [31:0] BEQ_M8  = 32'hFE000CE3;
  localparam logic [31:0] BEQ_P8  = 32'h00000463;
  localparam logic [31:0] JAL_P16 = 32'h0100006F;
  localparam logic [31:0] JALR    = 32'h000080E7;
  localparam logic [31:0] ADDI    = 32'h00000013;

  bpu_gshare #(.MODE(0)) u_m0 (.clk(clk), .rst(rst), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .pred_fire_i(pred_fire_i), .bp_result_o(res[0]), .bp_jump_addr_o(tgt[0]), .bp_ghr_o(ghr[0]),
    .upd_valid_i(upd_valid_i), .upd_addr_i(upd_addr_i), .upd_is_cond_i(upd_is_cond_i),
    .upd_is_jalr_i(upd_is_jalr_i), .upd_taken_i(upd_taken_i), .upd_target_i(upd_target_i),
    .upd_mispredict_i(upd_mispredict_i), .upd_ghr_i(upd_ghr_i));
  bpu_gshare #(.MODE(1)) u_m1 (.clk(clk), .rst(rst), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .pred_fire_i(pred_fire_i), .bp_result_o(res[1]), .bp_jump_addr_o(tgt[1]), .bp_ghr_o(ghr[1]),
    .upd_valid_i(upd_valid_i), .upd_addr_i(upd_addr_i), .upd_is_cond_i(upd_is_cond_i),
    .upd_is_jalr_i(upd_is_jalr_i), .upd_taken_i(upd_taken_i), .upd_target_i(upd_target_i),
    .upd_mispredict_i(upd_mispredict_i), .upd_ghr_i(upd_ghr_i));
  bpu_gshare #(.MODE(2)) u_m2 (.clk(clk), .rst(rst), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .pred_fire_i(pred_fire_i), .bp_result_o(res[2]), .bp_jump_addr_o(tgt[2]), .bp_ghr_o(ghr[2]),
    .upd_valid_i(upd_valid_i), .upd_addr_i(upd_addr_i), .upd_is_cond_i(upd_is_cond_i),
    .upd_is_jalr_i(upd_is_jalr_i), .upd_taken_i(upd_taken_i), .upd_target_i(upd_target_i),
    .upd_mispredict_i(upd_mispredict_i), .upd_ghr_i(upd_ghr_i));

  always @(posedge clk)
    if (!rst) assert (!(upd_valid_i && upd_is_cond_i && upd_is_jalr_i)) else $error("illegal cond+jalr update");

  // kind: 0 = direction, 1 = target, 2 = history snapshot
  typedef struct { string name; int d; int kind; logic [31:0] val; } exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0;

  task automatic exp_pred(string nm, int d, logic r, logic [31:0] t);
    sb.push_back('{nm, d, 0, {31'b0, r}});
    sb.push_back('{nm, d, 1, t});
  endtask

  task automatic exp_all(string nm, logic r, logic [31:0] t);
    for (int d = 0; d < 3; d++) exp_pred(nm, d, r, t);
  endtask

  task automatic exp_ghr(string nm, int d, logic [5:0] g);
    sb.push_back('{nm, d, 2, {26'b0, g}});
  endtask

  task automatic check_sb();
    exp_t e;
    logic [31:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        0:       act = {31'b0, res[e.d]};
        1:       act = tgt[e.d];
        default: act = {26'b0, ghr[e.d]};
      endcase
      n_chk++;
      if (act !== e.val) begin
        n_fail++;
        $display("FAIL %s mode%0d kind%0d: got %h expected %h", e.name, e.d, e.kind, act, e.val);
      end
    end
  endtask

  task automatic step();
    #2;
    check_sb();
    @(posedge clk);
    #1;
    rst = 1'b0; pred_fire_i = 1'b0; upd_valid_i = 1'b0; upd_is_cond_i = 1'b0;
    upd_is_jalr_i = 1'b0; upd_taken_i = 1'b0; upd_mispredict_i = 1'b0; upd_ghr_i = '0;
  endtask

  task automatic look(logic [31:0] pc, logic [31:0] ins);
    inst_addr_i = pc; inst_i = ins;
  endtask

  task automatic upd(logic [31:0] a, logic c, logic j, logic tk, logic [31:0] t, logic mp, logic [5:0] g);
    upd_valid_i = 1'b1; upd_addr_i = a; upd_is_cond_i = c; upd_is_jalr_i = j;
    upd_taken_i = tk; upd_target_i = t; upd_mispredict_i = mp; upd_ghr_i = g;
  endtask

  typedef struct { logic [31:0] ins; logic [31:0] pc; logic [2:0] r; logic [31:0] t0, t1, t2; } vec_t;
  typedef struct { logic uv; logic tk; logic pr; } sat_t;
  vec_t vt[6];
  sat_t sa[11];

  initial begin
    vt[0] = '{BEQ_M8,  32'h100, 3'b111, 32'hF8,  32'hF8,  32'hF8};
    vt[1] = '{JAL_P16, 32'h040, 3'b111, 32'h50,  32'h50,  32'h50};
    vt[2] = '{BEQ_P8,  32'h040, 3'b110, 32'h0,   32'h48,  32'h48};
    vt[3] = '{JALR,    32'h200, 3'b000, 32'h0,   32'h0,   32'h0};
    vt[4] = '{ADDI,    32'h000, 3'b000, 32'h0,   32'h0,   32'h0};
    vt[5] = '{BEQ_M8,  32'h300, 3'b111, 32'h2F8, 32'h2F8, 32'h2F8};
    // counter walk from CTR_INIT=2: prediction shown is the pre-update value
    sa[0] = '{1, 0, 1}; sa[1] = '{1, 0, 0}; sa[2]  = '{0, 0, 0}; sa[3] = '{1, 1, 0};
    sa[4] = '{1, 1, 0}; sa[5] = '{1, 1, 1}; sa[6]  = '{1, 1, 1}; sa[7] = '{1, 0, 1};
    sa[8] = '{0, 0, 1}; sa[9] = '{1, 0, 1}; sa[10] = '{0, 0, 0};

    rst = 1'b1; pred_fire_i = 1'b0; upd_valid_i = 1'b0; upd_is_cond_i = 1'b0; upd_is_jalr_i = 1'b0;
    upd_taken_i = 1'b0; upd_mispredict_i = 1'b0; upd_ghr_i = '0; upd_addr_i = '0; upd_target_i = '0;
    look(32'h100, BEQ_M8);
    #1;
    exp_all("reset_outputs", 1'b0, 32'h0);
    for (int d = 0; d < 3; d++) exp_ghr("reset_ghr", d, 6'd0);
    step();

    for (int i = 0; i < 6; i++) begin
      look(vt[i].pc, vt[i].ins);
      exp_pred("vec", 0, vt[i].r[0], vt[i].t0);
      exp_pred("vec", 1, vt[i].r[1], vt[i].t1);
      exp_pred("vec", 2, vt[i].r[2], vt[i].t2);
      for (int d = 0; d < 3; d++) exp_ghr("vec_ghr", d, 6'd0);
      step();
    end

    // Saturating counter walk; each update cycle also checks the no-bypass read.
    for (int i = 0; i < 11; i++) begin
      look(32'h100, BEQ_M8);
      if (sa[i].uv) upd(32'h100, 1'b1, 1'b0, sa[i].tk, 32'h0, 1'b0, 6'd0);
      exp_pred("sat_static", 0, 1'b1, 32'hF8);
      exp_pred("sat_bimodal", 1, sa[i].pr, sa[i].pr ? 32'hF8 : 32'h0);
      exp_pred("sat_gshare", 2, sa[i].pr, sa[i].pr ? 32'hF8 : 32'h0);
      step();
    end

    // gshare indexes the update with its history snapshot, bimodal ignores it.
    rst = 1'b1; step();
    for (int i = 0; i < 2; i++) begin
      upd(32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 6'b000011);
      step();
    end
    look(32'h100, BEQ_M8);
    exp_pred("gidx_bim_100", 1, 1'b0, 32'h0);
    exp_pred("gidx_gsh_100", 2, 1'b1, 32'hF8);
    step();
    look(32'h10C, BEQ_M8);
    exp_pred("gidx_bim_10c", 1, 1'b1, 32'h104);
    exp_pred("gidx_gsh_10c", 2, 1'b0, 32'h0);
    step();

    // BTB fill, hit, tag alias and reset in the middle of the sequence.
    look(32'h200, JALR);
    upd(32'h200, 1'b0, 1'b1, 1'b1, 32'h4000, 1'b0, 6'd0);
    exp_all("btb_same_cycle", 1'b0, 32'h0);
    step();
    look(32'h200, JALR); exp_all("btb_hit", 1'b1, 32'h4000); step();
    look(32'h240, JALR); exp_all("btb_tag_miss", 1'b0, 32'h0); step();
    look(32'h204, JALR); exp_all("btb_idx_miss", 1'b0, 32'h0); step();
    rst = 1'b1;
    look(32'h200, JALR);
    upd(32'h240, 1'b0, 1'b1, 1'b1, 32'h8000, 1'b0, 6'd0);
    exp_all("rst_mid_outputs", 1'b0, 32'h0);
    step();
    look(32'h200, JALR); exp_all("btb_after_rst", 1'b0, 32'h0); step();
    look(32'h240, JALR); exp_all("btb_upd_in_rst", 1'b0, 32'h0); step();
    look(32'h100, BEQ_M8); exp_all("pht_after_rst", 1'b1, 32'hF8); step();
    look(32'h10C, BEQ_M8); exp_pred("pht_after_rst_g", 2, 1'b1, 32'h104); step();

    // Speculative history, JAL not shifting, mispredict recovery beating the shift.
    rst = 1'b1; step();
    for (int i = 0; i < 3; i++) begin
      look(32'h100, BEQ_M8);
      pred_fire_i = 1'b1;
      for (int d = 0; d < 3; d++) exp_ghr("ghr_shift", d, 6'((1 << i) - 1));
      exp_all("ghr_shift_pred", 1'b1, 32'hF8);
      step();
    end
    look(32'h100, JAL_P16);
    pred_fire_i = 1'b1;
    for (int d = 0; d < 3; d++) exp_ghr("ghr_three", d, 6'b000111);
    exp_all("jal_fire", 1'b1, 32'h110);
    step();
    look(32'h100, BEQ_M8);
    pred_fire_i = 1'b1;
    upd(32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 6'b000001);
    for (int d = 0; d < 3; d++) exp_ghr("ghr_jal_noshift", d, 6'b000111);
    step();
    look(32'h100, BEQ_P8);
    pred_fire_i = 1'b1;
    for (int d = 0; d < 3; d++) exp_ghr("ghr_recover", d, 6'b000010);
    step();
    look(32'h0, ADDI);
    exp_ghr("ghr_shift_nt_static", 0, 6'b000100);
    exp_ghr("ghr_shift_nt_bimodal", 1, 6'b000100);
    exp_ghr("ghr_shift_t_gshare", 2, 6'b000101);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bpu_gshare.md
# bpu_gshare

Parametrised branch prediction unit for the fetch stage, successor to the fixed 32-entry predictor. It predicts JAL, conditional branches and JALR in the same cycle as fetch, and learns from resolved branches reported by execute. Three modes are provided: static, bimodal and gshare. It adds a speculative global history register with mispredict recovery and a tagged BTB for JALR targets.

## Interface
- MODE, 2: 0 = static backward-taken, 1 = bimodal PHT, 2 = gshare PHT (3 behaves as 2)
- PHT_IDX_W, 6: PHT has 2^PHT_IDX_W 2-bit counters
- GHR_W, 6: global history length; 1 ≤ GHR_W ≤ PHT_IDX_W
- BTB_IDX_W, 4: BTB has 2^BTB_IDX_W direct-mapped entries
- TAG_W, 8: BTB tag width
- CTR_INIT, 2'b10: counter value after reset (weakly taken)
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- inst_i  in  32  instruction being fetched
- inst_addr_i  in  32  PC of inst_i
- pred_fire_i  in  1  fetch accepts this cycle's prediction (not stalled or flushed)
- bp_result_o  out  1  predict taken
- bp_jump_addr_o  out  32  predicted target; `ZeroWord when not taken
- bp_ghr_o  out  GHR_W  GHR snapshot used for this prediction; the pipeline carries it to execute
- upd_valid_i  in  1  a resolved control-transfer instruction is reported
- upd_addr_i  in  32  PC of the resolved instruction
- upd_is_cond_i  in  1  resolved instruction was a B-type branch
- upd_is_jalr_i  in  1  resolved instruction was JALR
- upd_taken_i  in  1  actual direction
- upd_target_i  in  32  actual target (JALR)
- upd_mispredict_i  in  1  direction or target was mispredicted
- upd_ghr_i  in  GHR_W  bp_ghr_o snapshot carried with the instruction

## Operation
- Lookup is combinational from inst_i and inst_addr_i. Opcode is inst_i[6:0].
- JAL: taken in all modes; target = PC + J-immediate.
- B-type target = PC + B-immediate. Direction by mode:
  - mode 0: taken iff inst_i[31] = 1 (backward).
  - mode 1: PHT[pc_idx] ≥ 2'b10, with pc_idx = inst_addr_i[PHT_IDX_W+1:2].
  - mode 2: PHT[pc_idx ^ {0…, ghr}] ≥ 2'b10, with GHR zero-extended in the low bits.
- JALR: BTB index = inst_addr_i[BTB_IDX_W+1:2]; tag = inst_addr_i[BTB_IDX_W+TAG_W+1:BTB_IDX_W+2].
  - valid and tag match: taken, target = stored target.
  - otherwise: not taken.
- Any other opcode: bp_result_o = 0, bp_jump_addr_o = 0.
- All target additions are modulo 2^32.
- Conditional update (upd_valid_i & upd_is_cond_i), in all modes:
  - index = upd_addr_i[PHT_IDX_W+1:2], XORed with upd_ghr_i in mode ≥ 2.
  - counter saturates: +1 if taken (max 11), −1 if not taken (min 00).
- JALR update (upd_valid_i & upd_is_jalr_i): the BTB entry at upd_addr_i's index is written as valid=1, tag, upd_target_i, overwriting the old entry.
- GHR next-state priority:
  1. rst: GHR = 0.
  2. upd_valid_i & upd_is_cond_i & upd_mispredict_i: GHR = {upd_ghr_i[GHR_W-2:0], upd_taken_i}. For GHR_W = 1, GHR = upd_taken_i.
  3. pred_fire_i and inst_i is B-type: GHR = {GHR[GHR_W-2:0], bp_result_o}.
  4. otherwise: GHR holds.
- A mispredict in the same cycle as pred_fire_i drops the speculative shift. Fetch is being flushed in that cycle.
- JAL and JALR never shift the GHR.

## Timing
- Prediction latency: 0 cycles, combinational from inst_i, inst_addr_i and current state.
- Update latency: PHT, BTB and GHR change at the edge ending the update cycle. The first lookup to see the new value is in the next cycle.
- No bypass. A lookup and update to the same entry in the same cycle returns the old value.
- Reset, one cycle with rst = 1:
  - all PHT counters = CTR_INIT, all BTB valid bits = 0, GHR = 0.
  - while rst = 1, bp_result_o = 0, bp_jump_addr_o = 0, bp_ghr_o = 0.
  - Updates and pred_fire_i are ignored while rst = 1.
- An update with both upd_is_cond_i and upd_is_jalr_i set is illegal. Behaviour in that case is undefined, and the bench asserts it never occurs.

## Test plan
- Reset, MODE=2, inst_i=0xFE000CE3 (beq x0,x0,-8) at PC 0x100 -> bp_result_o=1, bp_jump_addr_o=0xF8, bp_ghr_o=0.
- MODE=1, two not-taken updates at 0x100 with upd_ghr_i=0 -> the next lookup of 0x100 gives bp_result_o=0 (counter 00). Three more taken updates return it to 11, and a further taken update holds it at 11.
- MODE=2, GHR_W=6, hold pred_fire_i for 3 predicted-taken branches -> bp_ghr_o=6'b000111. Then mispredict update with upd_ghr_i=6'b000001, upd_taken_i=0, same cycle as pred_fire_i -> GHR=6'b000010.
- JALR (0x000080E7) at 0x200: before any update -> bp_result_o=0. After update with upd_target_i=0x4000 -> next cycle bp_result_o=1, bp_jump_addr_o=0x4000. Same index, different tag (PC 0x200+2^(BTB_IDX_W+2)) -> miss.
- MODE=0, JAL +16 at 0x40 -> taken, target 0x50. Forward beq +8 -> not taken, target 0. Backward beq -> taken.
- Update and lookup of the same PHT entry in one cycle -> old prediction that cycle, new one the next. Assert rst mid-sequence -> all counters read CTR_INIT and the BTB misses on the following cycle.
